fpu_sequencer: RTL and testbench
================================

# fpu_sequencer

Single-outstanding-operation controller between the decode stage and the shared FPU bank. Accepts one floating-point request from decode (unit select plus operands), drives the operand buses and a one-cycle one-hot start pulse to the selected FPU unit, and waits for that unit's completion. Returns the result, or a timeout or illegal-unit error, over a valid/ready response channel. Replaces decode's direct control of `fpu_in_valid` and `fpu_data_*`.

## Interface
Parameters:
- `N_UNITS`, 10: number of FPU units; width of `fpu_in_valid`.
- `TIMEOUT`, 64: cycles allowed from issue to `fpu_out_valid` before aborting; legal range 2..255.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  1  decode offers an FPU operation.
- `req_ready`  out  1  high only in IDLE; the request transfers when `req_valid && req_ready`.
- `req_unit`  in  4  index of the target FPU unit.
- `req_a`, `req_b`  in  32  operands.
- `req_c`  in  8  function/rounding field.
- `fpu_data_a`, `fpu_data_b`  out  32  operand buses to the FPU bank.
- `fpu_data_c`  out  8  function bus to the FPU bank.
- `fpu_in_valid`  out  N_UNITS  one-hot start pulse.
- `fpu_out`  in  32  result from the active unit.
- `fpu_out_valid`  in  1  result strobe from the active unit.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  decode accepts the response.
- `resp_data`  out  32  result; 0 on error.
- `resp_err`  out  2  error code: 00 ok, 01 timeout, 10 illegal unit.
- `spurious_cnt`  out  8  saturating count of `fpu_out_valid` pulses seen outside ISSUE/WAIT.

## Operation
States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On handshake: latch unit, a, b, c.
  - If `req_unit < N_UNITS`, go to ISSUE.
  - Otherwise, go directly to RESP with `resp_err`=10 and `resp_data`=0. No pulse is issued.
- **ISSUE** (exactly 1 cycle)
  - `fpu_in_valid[unit]`=1; all other bits 0.
  - Clear the watchdog, then go to WAIT. If `fpu_out_valid` is high this cycle, capture and go to RESP instead.
- **WAIT**
  - `fpu_in_valid`=0.
  - When `fpu_out_valid`=1: capture `fpu_out` into `resp_data`, set `resp_err`=00, go to RESP.
  - Else, when the watchdog reaches TIMEOUT (cycles counted from ISSUE inclusive): set `resp_data`=0, `resp_err`=01, go to RESP.
  - If `fpu_out_valid` and the timeout occur in the same cycle, the result wins (err 00).
- **RESP**
  - `resp_valid`=1; data and err held stable until `resp_ready`, then go to IDLE.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Operand buses (`fpu_data_a/b/c`) are held from ISSUE until the next accepted request; they are never changed while the unit is busy.
- `fpu_out_valid` in IDLE or RESP: ignored for data; increments `spurious_cnt` (saturates at 255).

## Timing
- Reset values: state IDLE; `req_ready`=1 from the first post-reset cycle. All other outputs are 0: `resp_valid`, `resp_data`, `resp_err`, `fpu_in_valid`, `fpu_data_*`, `spurious_cnt`.
- Reset mid-operation: the operation is dropped and the state returns to IDLE. `fpu_in_valid` is 0 in the cycle after reset is sampled. No response is produced.
- Request handshake at cycle T:
  - ISSUE at T+1.
  - Minimum response at T+2 (unit answers in the ISSUE cycle).
  - A unit answering k cycles after the pulse gives `resp_valid` at T+2+k.
  - Timeout gives `resp_valid` at T+1+TIMEOUT, with `resp_err`=01.
- Illegal unit: `resp_valid` at T+1.
- Back-to-back throughput: at most one operation per 3 cycles (IDLE, ISSUE, RESP).
- `fpu_in_valid` is never high for more than one cycle per operation.

## Structure
- Package `fpu_seq_pkg`: state enum, `resp_err` code constants, default `N_UNITS`/`TIMEOUT` localparams.
- One natural sub-module: `fpu_watchdog`, an 8-bit counter with clear, enable and `expired` at TIMEOUT, synchronous reset.

## Test plan
- Unit 3, a=0x3F800000, b=0x40000000, c=0x00. Model answers 2 cycles after the pulse with 0x40400000. Required: `fpu_in_valid`=0x008 for exactly one cycle; `resp_data`=0x40400000, err 00, at T+4.
- Unit 12. Required: no pulse; `resp_valid` at T+1 with err 10, data 0.
- Unit 0, model never answers, TIMEOUT=64. Required: err 01, data 0, `resp_valid` at T+65. An answer arriving at exactly the TIMEOUT cycle instead gives err 00.
- `resp_ready` held low 5 cycles. Required: response stable; `req_ready`=0 throughout; a second request is accepted only after the response handshake.
- Assert `rst` during WAIT. Required: IDLE next cycle, all outputs 0. Then 300 stray `fpu_out_valid` pulses in IDLE leave `spurious_cnt`=255.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FPU sequencer: state encoding,
// response error codes and default sizing.
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  localparam int N_UNITS_DEF = 10;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/fpu_sequencer_if.sv
// Bundle of the decode request/response channels and the FPU bank buses.
// master = decode plus FPU bank side, slave = the sequencer.
interface fpu_sequencer_if #(
  parameter int N_UNITS = 10
);
  logic               req_valid;
  logic               req_ready;
  logic [3:0]         req_unit;
  logic [31:0]        req_a;
  logic [31:0]        req_b;
  logic [7:0]         req_c;
  logic [31:0]        fpu_data_a;
  logic [31:0]        fpu_data_b;
  logic [7:0]         fpu_data_c;
  logic [N_UNITS-1:0] fpu_in_valid;
  logic [31:0]        fpu_out;
  logic               fpu_out_valid;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_data;
  logic [1:0]         resp_err;
  logic [7:0]         spurious_cnt;

  modport master (
    output req_valid, req_unit, req_a, req_b, req_c, fpu_out, fpu_out_valid, resp_ready,
    input  req_ready, fpu_data_a, fpu_data_b, fpu_data_c, fpu_in_valid,
           resp_valid, resp_data, resp_err, spurious_cnt
  );

  modport slave (
    input  req_valid, req_unit, req_a, req_b, req_c, fpu_out, fpu_out_valid, resp_ready,
    output req_ready, fpu_data_a, fpu_data_b, fpu_data_c, fpu_in_valid,
           resp_valid, resp_data, resp_err, spurious_cnt
  );
endinterface

// File: rtl/fpu_sequencer_watchdog.sv
// Issue-to-completion watchdog: down-counter loaded on clear, flags the
// TIMEOUT-th enabled cycle after the clear.
module fpu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [7:0] LOAD = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign expired = enable && (count == 8'd0);

endmodule

// File: rtl/fpu_sequencer.sv
// Single-outstanding FPU operation controller: issues a one-hot start pulse,
// waits for the unit (or the watchdog) and returns the result to decode.
//
// state    | meaning
// ST_IDLE  | ready for a decode request
// ST_ISSUE | one-cycle start pulse to the selected unit
// ST_WAIT  | waiting for fpu_out_valid or watchdog expiry
// ST_RESP  | response held until decode accepts it
module fpu_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int N_UNITS = N_UNITS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic            clk,
  input logic            rst,
  fpu_sequencer_if.slave bus
);
  localparam logic [N_UNITS-1:0] ONE_HOT_BASE = N_UNITS'(1);

  state_t             state;
  logic               accept;
  logic               unit_legal;
  logic               wd_expired;
  logic               wd_enable;
  logic [N_UNITS-1:0] unit_onehot;

  assign accept      = (state == ST_IDLE) && bus.req_valid;
  assign unit_legal  = {28'd0, bus.req_unit} < 32'(N_UNITS);
  assign unit_onehot = ONE_HOT_BASE << bus.req_unit;
  assign wd_enable   = (state == ST_ISSUE) || (state == ST_WAIT);

  // Loaded on acceptance so the ISSUE cycle counts as the first watchdog cycle.
  fpu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      bus.req_ready    <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_data    <= '0;
      bus.resp_err     <= ERR_OK;
      bus.fpu_in_valid <= '0;
      bus.fpu_data_a   <= '0;
      bus.fpu_data_b   <= '0;
      bus.fpu_data_c   <= '0;
      bus.spurious_cnt <= '0;
    end else begin
      bus.fpu_in_valid <= '0;

      if (bus.fpu_out_valid && (state == ST_IDLE || state == ST_RESP) &&
          bus.spurious_cnt != 8'hFF) begin
        bus.spurious_cnt <= bus.spurious_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready  <= 1'b0;
            bus.fpu_data_a <= bus.req_a;
            bus.fpu_data_b <= bus.req_b;
            bus.fpu_data_c <= bus.req_c;
            if (unit_legal) begin
              bus.fpu_in_valid <= unit_onehot;
              state            <= ST_ISSUE;
            end else begin
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_err   <= ERR_ILLEGAL;
              state          <= ST_RESP;
            end
          end
        end

        ST_ISSUE, ST_WAIT: begin
          // A result in the expiry cycle still counts as a completion.
          if (bus.fpu_out_valid) begin
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= bus.fpu_out;
            bus.resp_err   <= ERR_OK;
            state          <= ST_RESP;
          end else if (wd_expired) begin
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= '0;
            bus.resp_err   <= ERR_TIMEOUT;
            state          <= ST_RESP;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: table of operations with an FPU
// response model and a response scoreboard, plus reset and stray-strobe sequences.
module tb_fpu_sequencer;
  localparam int NU  = 10;
  localparam int TMO = 64;

  typedef struct {
    logic [3:0]  unit;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  c;
    int          lat;
    logic [31:0] res;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[7];

  fpu_sequencer_if #(.N_UNITS(NU)) bus();

  fpu_sequencer #(.N_UNITS(NU), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "bench stalled");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_op(input vec_t v);
    exp_t        e;
    exp_t        got;
    int          t0;
    int          pulse_k;
    int          npulse;
    bit          done;
    logic [NU-1:0] pv;
    logic [NU-1:0] one;
    one = NU'(1);
    pv = '0;
    if (v.unit >= 4'(NU)) begin
      e.data = 32'h0; e.err = 2'b10; e.lat = 1;
    end else if (v.lat >= 0 && v.lat <= TMO - 1) begin
      e.data = v.res; e.err = 2'b00; e.lat = 2 + v.lat;
    end else begin
      e.data = 32'h0; e.err = 2'b01; e.lat = 1 + TMO;
    end

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_unit  = v.unit;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.req_c     = v.c;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    t0 = cyc;
    sb.push_back(e);

    pulse_k = -1;
    npulse  = 0;
    done    = 1'b0;
    for (int k = 1; k <= TMO + 10 && !done; k++) begin
      @(negedge clk);
      bus.req_valid     = 1'b0;
      bus.fpu_out_valid = 1'b0;
      if (bus.resp_valid) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          got = sb.pop_front();
          chk("resp_latency", 32'(cyc - t0), 32'(got.lat));
          chk("resp_data", bus.resp_data, got.data);
          chk("resp_err", 32'(bus.resp_err), 32'(got.err));
        end
      end else begin
        if (|bus.fpu_in_valid) begin
          npulse++;
          pv = bus.fpu_in_valid;
          pulse_k = k;
          chk("fpu_data_a", bus.fpu_data_a, v.a);
          chk("fpu_data_b", bus.fpu_data_b, v.b);
          chk("fpu_data_c", 32'(bus.fpu_data_c), 32'(v.c));
        end
        if (pulse_k >= 0 && v.lat >= 0 && (k - pulse_k) == v.lat) begin
          bus.fpu_out_valid = 1'b1;
          bus.fpu_out       = v.res;
        end
      end
    end
    if (!done) chk("resp_seen_within_budget", 32'd0, 32'd1);

    chk("pulse_count", 32'(npulse), (v.unit < 4'(NU)) ? 32'd1 : 32'd0);
    chk("pulse_vector", 32'(pv), (v.unit < 4'(NU)) ? 32'(one << v.unit) : 32'd0);

    for (int h = 0; h < v.hold; h++) begin
      // A competing request sits on the bus while the response is pending.
      bus.req_valid = 1'b1;
      bus.req_unit  = 4'd1;
      @(negedge clk);
      chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_resp_data", bus.resp_data, e.data);
      chk("hold_resp_err", 32'(bus.resp_err), 32'(e.err));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_no_pulse", 32'(bus.fpu_in_valid), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    chk("after_hs_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("after_hs_req_ready", 32'(bus.req_ready), 32'd1);
    chk("after_hs_no_pulse", 32'(bus.fpu_in_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{unit: 4'd3,  a: 32'h3F800000, b: 32'h40000000, c: 8'h00, lat: 2,  res: 32'h40400000, hold: 0};
    vecs[1] = '{unit: 4'd12, a: 32'h11111111, b: 32'h22222222, c: 8'h33, lat: 0,  res: 32'hDEADBEEF, hold: 0};
    vecs[2] = '{unit: 4'd0,  a: 32'hC0000000, b: 32'h3F000000, c: 8'h05, lat: -1, res: 32'h0,        hold: 0};
    vecs[3] = '{unit: 4'd0,  a: 32'h12345678, b: 32'h9ABCDEF0, c: 8'hA5, lat: 63, res: 32'hCAFEF00D, hold: 0};
    vecs[4] = '{unit: 4'd9,  a: 32'h7F7FFFFF, b: 32'h00800000, c: 8'h7E, lat: 0,  res: 32'h0BADF00D, hold: 5};
    vecs[5] = '{unit: 4'd10, a: 32'hFFFFFFFF, b: 32'h00000001, c: 8'hFF, lat: 0,  res: 32'h55555555, hold: 2};
    vecs[6] = '{unit: 4'd5,  a: 32'h41200000, b: 32'hC1200000, c: 8'h12, lat: 7,  res: 32'h00000000, hold: 1};

    bus.req_valid     = 1'b0;
    bus.req_unit      = '0;
    bus.req_a         = '0;
    bus.req_b         = '0;
    bus.req_c         = '0;
    bus.fpu_out       = '0;
    bus.fpu_out_valid = 1'b0;
    bus.resp_ready    = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_fpu_in_valid", 32'(bus.fpu_in_valid), 32'd0);
    chk("rst_fpu_data_a", bus.fpu_data_a, 32'd0);
    chk("rst_spurious", 32'(bus.spurious_cnt), 32'd0);

    for (int i = 0; i < 7; i++) do_op(vecs[i]);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("no_spurious_in_ops", 32'(bus.spurious_cnt), 32'd0);

    // Reset while the unit is busy: operation dropped, no response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_unit  = 4'd2;
    bus.req_a     = 32'hA5A5A5A5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_fpu_in_valid", 32'(bus.fpu_in_valid), 32'd0);
    chk("midrst_fpu_data_a", bus.fpu_data_a, 32'd0);
    chk("midrst_resp_err", 32'(bus.resp_err), 32'd0);

    for (int i = 0; i < 300; i++) begin
      bus.fpu_out_valid = 1'b1;
      bus.fpu_out       = 32'(i);
      @(negedge clk);
      if (i == 9) chk("spurious_10", 32'(bus.spurious_cnt), 32'd10);
    end
    bus.fpu_out_valid = 1'b0;
    @(negedge clk);
    chk("spurious_sat", 32'(bus.spurious_cnt), 32'd255);
    chk("stray_no_resp", 32'(bus.resp_valid), 32'd0);
    chk("stray_req_ready", 32'(bus.req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
